// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer and its next-PC unit.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_e;

  localparam int PC_INCR      = 4;
  localparam int BRANCH_SHIFT = 2;
  localparam int INST_W       = 32;

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC: sequential +4 or PC-relative word-offset branch.
module pc_next_unit
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_branch_offset,
  input  logic              i_branch,
  input  logic              i_uncond_branch,
  input  logic              i_zero,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic              w_taken;
  logic [ADDR_W-1:0] w_incr;

  // CBZ takes on zero; B always takes. Sum wraps modulo 2^ADDR_W.
  assign w_taken   = (i_branch & i_zero) | i_uncond_branch;
  assign w_incr    = w_taken ? (i_branch_offset << BRANCH_SHIFT) : ADDR_W'(PC_INCR);
  assign o_next_pc = i_pc + w_incr;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer owning the PC and instruction register.
// Optional retire counter port enabled by defining FETCH_SEQ_PERF_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [INST_W-1:0] i_imem_data,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_branch,
  input  logic              i_uncond_branch,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_branch_offset,
  input  logic              i_exec_done,
  output logic [ADDR_W-1:0] o_pc,
  output logic [1:0]        o_state
`ifdef FETCH_SEQ_PERF_EN
  ,output logic [31:0]      o_retire_count
`endif
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_inst_load;
  logic              w_retire;

  pc_next_unit #(.ADDR_W(ADDR_W)) u_pc_next (
    .i_pc            (r_pc),
    .i_branch_offset (i_branch_offset),
    .i_branch        (i_branch),
    .i_uncond_branch (i_uncond_branch),
    .i_zero          (i_zero),
    .o_next_pc       (w_pc_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire)    r_pc   <= w_pc_nxt;
      if (w_inst_load) r_inst <= i_imem_data;
    end
  end

  // Acks and done strobes only count in their own state; Run is looked at
  // only in IDLE and on completion so a drop never aborts an instruction.
  always_comb begin
    w_state_nxt  = r_state;
    w_inst_load  = 1'b0;
    w_retire     = 1'b0;
    o_imem_req   = 1'b0;
    o_inst_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_inst_load = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        o_inst_valid = 1'b1;
        w_state_nxt  = ST_EXEC;
      end
      ST_EXEC: begin
        if (i_exec_done) begin
          w_retire    = 1'b1;
          w_state_nxt = i_run ? ST_FETCH : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_inst      = r_inst;
  assign o_state     = r_state;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_retire_cnt <= '0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign o_retire_count = r_retire_cnt;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle controller that sequences the program counter, instruction memory and instruction decoder. It owns the PC register and issues fetch requests to an instruction memory with variable latency. It holds each fetched word in an instruction register for the decoder, then waits for the datapath to finish the instruction before selecting the next PC (sequential or branch target). It sits between the top-level run control and the PC/IM/ID datapath, and replaces free-running PC clocking with an explicit fetch/decode/execute handshake.

## Interface
- ADDR_W, 64, PC and instruction-address width
- RESET_PC, 64'h0, PC value loaded on reset

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Run  in  1  enables sequencing; low parks the block in IDLE after the current instruction
- ImemReq  out  1  fetch request to instruction memory
- ImemAddr  out  ADDR_W  fetch address; equals PCOut
- ImemAck  in  1  instruction memory has valid ImemData this cycle
- ImemData  in  32  fetched instruction word
- InstOut  out  32  instruction register, feeds decoder OpcodeField [31:21]
- InstValid  out  1  one-cycle pulse: InstOut newly valid
- Branch  in  1  conditional branch (CBZ) flag from decoder
- UncondBranch  in  1  unconditional branch (B) flag from decoder
- Zero  in  1  ALU zero flag
- BranchOffset  in  ADDR_W  sign-extended word offset
- ExecDone  in  1  datapath has finished the current instruction
- PCOut  out  ADDR_W  current PC
- State  out  2  current FSM state, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3.
- IDLE: ImemReq=0. Run=1 → FETCH on the next edge.
- FETCH: ImemReq=1 combinationally. ImemAck=1 at an edge latches ImemData into InstOut and moves to DECODE. Otherwise the block stays in FETCH, with ImemAddr held stable.
- DECODE: exactly one cycle. InstValid=1. → EXEC.
- EXEC: waits for ExecDone. ExecDone=1 at an edge takes the branch if (Branch & Zero) | UncondBranch.
  - Taken: PC ← PC + (BranchOffset << 2).
  - Not taken: PC ← PC + 4.
  - Next state is FETCH if Run=1, else IDLE.
- PC arithmetic is modulo 2^ADDR_W. Wrap from all-ones-minus-3 +4 gives 0. Negative offsets wrap the same way.
- ImemAck outside FETCH and ExecDone outside EXEC are ignored.
- Branch/UncondBranch/Zero/BranchOffset are sampled only on the ExecDone edge.
- Run deasserting in FETCH/DECODE/EXEC does not abort. The current instruction completes, then the block enters IDLE.
- Run is sampled in IDLE and at EXEC completion only.

## Timing
- Reset values: PCOut=RESET_PC, InstOut=0, InstValid=0, ImemReq=0, State=IDLE.
- Reset asserted mid-operation: immediate return to reset values; any in-flight ImemAck is discarded.
- Minimum instruction period is 3 cycles: FETCH with same-cycle ack, DECODE, EXEC with same-cycle ExecDone.
- From IDLE with Run=1: first ImemReq appears 1 cycle after the edge that sampled Run.
- PCOut updates on the ExecDone edge. ImemAddr for the next fetch is valid in the same cycle that FETCH is entered.
- InstOut is stable from DECODE until the next accepted ImemAck.

## Configuration
- FETCH_SEQ_PERF_EN defined:
  - Adds output RetireCount (32 bits), reset to 0.
  - Increments by 1 on every accepted ExecDone in EXEC.
  - Wraps 32'hFFFFFFFF → 0.
- FETCH_SEQ_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package fetch_seq_pkg holds:
  - the state enum (IDLE/FETCH/DECODE/EXEC, 2 bits)
  - PC_INCR=4
  - BRANCH_SHIFT=2
  - INST_W=32
- Sub-module pc_next_unit: combinational next-PC logic. Inputs are PC, BranchOffset, Branch, UncondBranch and Zero; output is the next PC. It holds the adder and mux and is instantiated once. The PC register and FSM stay in fetch_sequencer.

## Test plan
- Reset then Run=1, ImemAck immediate, ExecDone immediate, no branches → PCOut goes 0,4,8,12; InstValid pulses every 3 cycles.
- ImemAck delayed 5 cycles in FETCH → ImemReq held 6 cycles, ImemAddr constant, InstOut latches ImemData=32'h8B020020 only on the ack edge.
- PC=0x10, Branch=1, Zero=1, BranchOffset=-2 at ExecDone → PCOut=0x08; repeat with Zero=0 → PCOut=0x14; UncondBranch=1, offset=+3 → PCOut=0x1C.
- PC=64'hFFFF_FFFF_FFFF_FFFC, sequential completion → PCOut=0.
- Run dropped during EXEC → instruction completes, PC advances, State=IDLE, no further ImemReq; Reset pulsed during FETCH → PCOut=RESET_PC, State=IDLE same cycle.
- With FETCH_SEQ_PERF_EN: 5 instructions retired → RetireCount=5; force counter to 32'hFFFFFFFF, retire one → 0.
